thread_scheduler: RTL and testbench

//  Barrel-thread fetch scheduler for the multithreaded core. Holds one PC and one run state per

---
 rtl/thread_scheduler_pkg.sv | 24 ++
 rtl/thread_scheduler_rr_arbiter.sv | 34 +++
 rtl/thread_scheduler.sv | 158 +++++++++++++++
 tb/tb_thread_scheduler.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thread_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : thread_scheduler_pkg
//  Brief    : Shared thread-state and thread-id types for the fetch scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package thread_scheduler_pkg;

    localparam int NTHREADS_MAX = 4;
    localparam int TID_W        = $clog2(NTHREADS_MAX);

    typedef logic [TID_W-1:0] tid_t;

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        HALT = 2'd3
    } thread_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0800;

endpackage
`default_nettype wire

// File: rtl/thread_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational round-robin arbiter; search starts after last grant.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        return IW'((int'(base) + off) % N);
    endfunction

    always_comb begin
        grant = '0;
        valid = 1'b0;
        // Offset N lands back on last itself, so a lone requester is still served.
        for (int off = 1; off <= N; off++) begin
            if (!valid && req[wrap_idx(last, off)]) begin
                grant[wrap_idx(last, off)] = 1'b1;
                valid                      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/thread_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : thread_scheduler
//  Brief    : Barrel-thread fetch scheduler; one round-robin fetch per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module thread_scheduler
    import thread_scheduler_pkg::*;
#(
    parameter int              NTHREADS = 3,
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NTHREADS-1:0] start_mask,
    input  logic                redirect_valid,
    input  logic [1:0]          redirect_tid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                stall_valid,
    input  logic [1:0]          stall_tid,
    input  logic                wake_valid,
    input  logic [1:0]          wake_tid,
    input  logic                halt_valid,
    input  logic [1:0]          halt_tid,
    output logic                fetch_valid,
    output logic [1:0]          fetch_tid,
    output logic [XLEN-1:0]     fetch_pc,
    output logic [NTHREADS-1:0] run_mask
);

    localparam int              c_IW       = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
    localparam logic [XLEN-1:0] c_PC_STEP  = XLEN'(4);
    localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(NTHREADS - 1);

    thread_state_e       r_state     [NTHREADS];
    thread_state_e       w_state_nxt [NTHREADS];
    logic [XLEN-1:0]     r_pc        [NTHREADS];
    logic [XLEN-1:0]     w_pc_nxt    [NTHREADS];
    logic [c_IW-1:0]     r_last_tid;

    logic                r_fetch_valid;
    tid_t                r_fetch_tid;
    logic [XLEN-1:0]     r_fetch_pc;
    logic [NTHREADS-1:0] r_run_mask;

    logic [NTHREADS-1:0] w_stall_hit;
    logic [NTHREADS-1:0] w_halt_hit;
    logic [NTHREADS-1:0] w_wake_hit;
    logic [NTHREADS-1:0] w_redir_hit;
    logic [NTHREADS-1:0] w_eligible;
    logic [NTHREADS-1:0] w_grant;
    logic [NTHREADS-1:0] w_run_nxt;
    logic                w_grant_valid;
    logic [c_IW-1:0]     w_win_idx;
    logic [XLEN-1:0]     w_redir_pc;
    logic [XLEN-1:0]     w_win_pc;

    assign w_redir_pc = {redirect_pc[XLEN-1:2], 2'b00};

    // Event tids at or above NTHREADS match no entry and therefore fall away.
    always_comb begin : decode
        for (int t = 0; t < NTHREADS; t++) begin
            w_stall_hit[t] = stall_valid    && (stall_tid    == tid_t'(t));
            w_halt_hit[t]  = halt_valid     && (halt_tid     == tid_t'(t));
            w_wake_hit[t]  = wake_valid     && (wake_tid     == tid_t'(t));
            w_redir_hit[t] = redirect_valid && (redirect_tid == tid_t'(t));
            w_eligible[t]  = (r_state[t] == RUN) && !w_stall_hit[t] && !w_halt_hit[t];
        end
    end

    rr_arbiter #(
        .N  (NTHREADS),
        .IW (c_IW)
    ) u_rr_arbiter (
        .req   (w_eligible),
        .last  (r_last_tid),
        .grant (w_grant),
        .valid (w_grant_valid)
    );

    always_comb begin : win_select
        w_win_idx = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (w_grant[t]) begin
                w_win_idx = c_IW'(t);
            end
        end
        w_win_pc = w_redir_hit[w_win_idx] ? w_redir_pc : r_pc[w_win_idx];
    end

    always_comb begin : next_thread
        for (int t = 0; t < NTHREADS; t++) begin
            w_state_nxt[t] = r_state[t];
            w_pc_nxt[t]    = r_pc[t];

            // A redirect that coincides with a grant has already been fetched via the bypass.
            if (w_redir_hit[t]) begin
                w_pc_nxt[t] = w_grant[t] ? (w_redir_pc + c_PC_STEP) : w_redir_pc;
            end else if (w_grant[t]) begin
                w_pc_nxt[t] = r_pc[t] + c_PC_STEP;
            end

            case (r_state[t])
                OFF: begin
                    if (w_redir_hit[t]) w_state_nxt[t] = RUN;
                end
                RUN: begin
                    if (w_halt_hit[t])       w_state_nxt[t] = HALT;
                    else if (w_stall_hit[t]) w_state_nxt[t] = WAIT;
                end
                WAIT: begin
                    if (w_halt_hit[t])                        w_state_nxt[t] = HALT;
                    else if (!w_stall_hit[t] && w_wake_hit[t]) w_state_nxt[t] = RUN;
                end
                HALT: begin
                    if (!w_halt_hit[t] && !w_stall_hit[t] && w_wake_hit[t]) w_state_nxt[t] = RUN;
                end
                default: w_state_nxt[t] = r_state[t];
            endcase

            w_run_nxt[t] = (w_state_nxt[t] == RUN);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_pc[t]    <= RESET_PC;
                r_state[t] <= start_mask[t] ? RUN : OFF;
            end
            r_last_tid    <= c_LAST_RST;
            r_fetch_valid <= 1'b0;
            r_fetch_tid   <= '0;
            r_fetch_pc    <= RESET_PC;
            r_run_mask    <= '0;
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_pc[t]    <= w_pc_nxt[t];
                r_state[t] <= w_state_nxt[t];
            end
            r_fetch_valid <= w_grant_valid;
            r_run_mask    <= w_run_nxt;
            if (w_grant_valid) begin
                r_last_tid  <= w_win_idx;
                r_fetch_tid <= tid_t'(w_win_idx);
                r_fetch_pc  <= w_win_pc;
            end
        end
    end

    assign fetch_valid = r_fetch_valid;
    assign fetch_tid   = r_fetch_tid;
    assign fetch_pc    = r_fetch_pc;
    assign run_mask    = r_run_mask;

endmodule
`default_nettype wire

// File: tb/tb_thread_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_thread_scheduler
//  Brief    : Self-checking bench for thread_scheduler with a reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_thread_scheduler;

    localparam int          NT   = 3;
    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h0000_0800;
    localparam int M_OFF = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NT-1:0]   start_mask = '1;
    logic            redirect_valid = 1'b0;
    logic [1:0]      redirect_tid = '0;
    logic [XLEN-1:0] redirect_pc = '0;
    logic            stall_valid = 1'b0;
    logic [1:0]      stall_tid = '0;
    logic            wake_valid = 1'b0;
    logic [1:0]      wake_tid = '0;
    logic            halt_valid = 1'b0;
    logic [1:0]      halt_tid = '0;
    logic            fetch_valid;
    logic [1:0]      fetch_tid;
    logic [XLEN-1:0] fetch_pc;
    logic [NT-1:0]   run_mask;

    thread_scheduler #(
        .NTHREADS (NT),
        .XLEN     (XLEN),
        .RESET_PC (RPC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start_mask     (start_mask),
        .redirect_valid (redirect_valid),
        .redirect_tid   (redirect_tid),
        .redirect_pc    (redirect_pc),
        .stall_valid    (stall_valid),
        .stall_tid      (stall_tid),
        .wake_valid     (wake_valid),
        .wake_tid       (wake_tid),
        .halt_valid     (halt_valid),
        .halt_tid       (halt_tid),
        .fetch_valid    (fetch_valid),
        .fetch_tid      (fetch_tid),
        .fetch_pc       (fetch_pc),
        .run_mask       (run_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int          m_state [NT];
    logic [31:0] m_pc    [NT];
    int          m_last;
    logic        e_fv;
    logic [1:0]  e_tid;
    logic [31:0] e_pc;
    logic [NT-1:0] e_run;

    function automatic bit hit(input logic v, input logic [1:0] id, input int t);
        return v && (int'(id) == t);
    endfunction

    // Reference model: one call per rising edge, using the inputs held across it.
    task automatic model_step();
        int          win;
        int          t;
        int          ev;
        logic [31:0] rpc;
        if (rst) begin
            for (int k = 0; k < NT; k++) begin
                m_pc[k]    = RPC;
                m_state[k] = start_mask[k] ? M_RUN : M_OFF;
            end
            m_last = NT - 1;
            e_fv = 1'b0; e_tid = 2'd0; e_pc = RPC; e_run = '0;
        end else begin
            win = -1;
            rpc = redirect_pc & ~32'h3;
            for (int k = 1; k <= NT; k++) begin
                t = (m_last + k) % NT;
                if (win < 0 && m_state[t] == M_RUN &&
                    !hit(stall_valid, stall_tid, t) && !hit(halt_valid, halt_tid, t))
                    win = t;
            end
            e_fv = (win >= 0);
            if (win >= 0) begin
                e_tid = 2'(win);
                e_pc  = hit(redirect_valid, redirect_tid, win) ? rpc : m_pc[win];
                m_last = win;
                m_pc[win] = m_pc[win] + 32'd4;
            end
            for (int k = 0; k < NT; k++) begin
                if (hit(redirect_valid, redirect_tid, k))
                    m_pc[k] = rpc + ((k == win) ? 32'd4 : 32'd0);
                if (hit(halt_valid, halt_tid, k))       ev = 1;
                else if (hit(stall_valid, stall_tid, k)) ev = 2;
                else if (hit(wake_valid, wake_tid, k))   ev = 3;
                else                                     ev = 0;
                case (m_state[k])
                    M_OFF:  if (hit(redirect_valid, redirect_tid, k)) m_state[k] = M_RUN;
                    M_RUN:  m_state[k] = (ev == 1) ? M_HALT : (ev == 2) ? M_WAIT : M_RUN;
                    M_WAIT: m_state[k] = (ev == 1) ? M_HALT : (ev == 3) ? M_RUN : M_WAIT;
                    default: m_state[k] = (ev == 3) ? M_RUN : M_HALT;
                endcase
                e_run[k] = (m_state[k] == M_RUN);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic clear_events();
        redirect_valid = 1'b0;
        stall_valid    = 1'b0;
        wake_valid     = 1'b0;
        halt_valid     = 1'b0;
    endtask

    task automatic do_reset(input logic [NT-1:0] mask);
        clear_events();
        rst = 1'b1; start_mask = mask;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(3'b111);
        rst = 1'b1;
        tick();
        n_checks++;
        if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid got=%b want=0", fetch_valid); end
        n_checks++;
        if (fetch_tid !== 2'd0) begin n_fail++; $display("FAIL reset_fetch_tid got=%0d want=0", fetch_tid); end
        n_checks++;
        if (fetch_pc !== RPC) begin n_fail++; $display("FAIL reset_fetch_pc got=%h want=%h", fetch_pc, RPC); end
        n_checks++;
        if (run_mask !== 3'b000) begin n_fail++; $display("FAIL reset_run_mask got=%b want=000", run_mask); end
    endtask

    task automatic test_rotation();
        logic [31:0] exp_pc;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_pc = RPC + 32'(4 * (i / 3));
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_tid !== 2'(i % 3) || fetch_pc !== exp_pc) begin
                n_fail++;
                $display("FAIL rotation[%0d] got v=%b tid=%0d pc=%h want v=1 tid=%0d pc=%h",
                         i, fetch_valid, fetch_tid, fetch_pc, i % 3, exp_pc);
            end
        end
        n_checks++;
        if (run_mask !== 3'b111) begin n_fail++; $display("FAIL rotation_run_mask got=%b want=111", run_mask); end
    endtask

    task automatic test_single_start();
        do_reset(3'b001);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_tid !== 2'd0 || fetch_pc !== RPC + 32'(4 * i)) begin
                n_fail++;
                $display("FAIL single_tid0[%0d] got v=%b tid=%0d pc=%h want v=1 tid=0 pc=%h",
                         i, fetch_valid, fetch_tid, fetch_pc, RPC + 32'(4 * i));
            end
        end
        redirect_valid = 1'b1; redirect_tid = 2'd1; redirect_pc = 32'h0000_1000;
        tick();
        clear_events();
        n_checks++;
        if (fetch_tid !== 2'd0 || fetch_pc !== 32'h80C) begin
            n_fail++; $display("FAIL single_redirect_cycle got tid=%0d pc=%h want tid=0 pc=0000080c", fetch_tid, fetch_pc);
        end
        tick();
        n_checks++;
        if (fetch_valid !== 1'b1 || fetch_tid !== 2'd1 || fetch_pc !== 32'h1000) begin
            n_fail++; $display("FAIL single_tid1_start got v=%b tid=%0d pc=%h want v=1 tid=1 pc=00001000", fetch_valid, fetch_tid, fetch_pc);
        end
        tick();
        n_checks++;
        if (fetch_tid !== 2'd0 || fetch_pc !== 32'h810) begin
            n_fail++; $display("FAIL single_after_start got tid=%0d pc=%h want tid=0 pc=00000810", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_stall_wake();
        logic [1:0]  exp_tid;
        logic [31:0] exp_pc;
        do_reset(3'b111);
        tick();
        stall_valid = 1'b1; stall_tid = 2'd1;
        tick();
        clear_events();
        n_checks++;
        if (fetch_tid !== 2'd2 || fetch_pc !== RPC) begin
            n_fail++; $display("FAIL stall_skip got tid=%0d pc=%h want tid=2 pc=%h", fetch_tid, fetch_pc, RPC);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_tid = (i % 2 == 0) ? 2'd0 : 2'd2;
            exp_pc  = RPC + 32'(4 * (1 + i / 2));
            n_checks++;
            if (fetch_tid !== exp_tid || fetch_pc !== exp_pc) begin
                n_fail++; $display("FAIL stall_rotation[%0d] got tid=%0d pc=%h want tid=%0d pc=%h", i, fetch_tid, fetch_pc, exp_tid, exp_pc);
            end
        end
        wake_valid = 1'b1; wake_tid = 2'd1;
        tick();
        clear_events();
        tick();
        n_checks++;
        if (fetch_tid !== 2'd1 || fetch_pc !== RPC) begin
            n_fail++; $display("FAIL wake_resume got tid=%0d pc=%h want tid=1 pc=%h", fetch_tid, fetch_pc, RPC);
        end
    endtask

    task automatic test_redirect_bypass();
        do_reset(3'b111);
        redirect_valid = 1'b1; redirect_tid = 2'd0; redirect_pc = 32'h0000_2000;
        tick();
        clear_events();
        n_checks++;
        if (fetch_tid !== 2'd0 || fetch_pc !== 32'h2000) begin
            n_fail++; $display("FAIL bypass_pc got tid=%0d pc=%h want tid=0 pc=00002000", fetch_tid, fetch_pc);
        end
        tick(); tick(); tick();
        n_checks++;
        if (fetch_tid !== 2'd0 || fetch_pc !== 32'h2004) begin
            n_fail++; $display("FAIL bypass_next got tid=%0d pc=%h want tid=0 pc=00002004", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_halt_wrap();
        halt_valid = 1'b1; halt_tid = 2'd2; wake_valid = 1'b1; wake_tid = 2'd2;
        tick();
        clear_events();
        n_checks++;
        if (run_mask !== 3'b011 || fetch_tid !== 2'd1) begin
            n_fail++; $display("FAIL halt_over_wake got mask=%b tid=%0d want mask=011 tid=1", run_mask, fetch_tid);
        end
        tick();
        redirect_valid = 1'b1; redirect_tid = 2'd0; redirect_pc = 32'hFFFF_FFFF;
        stall_valid = 1'b1; stall_tid = 2'd3;
        tick();
        clear_events();
        n_checks++;
        if (fetch_tid !== 2'd1 || fetch_pc !== 32'h808) begin
            n_fail++; $display("FAIL oob_stall_ignored got tid=%0d pc=%h want tid=1 pc=00000808", fetch_tid, fetch_pc);
        end
        tick();
        n_checks++;
        if (fetch_tid !== 2'd0 || fetch_pc !== 32'hFFFF_FFFC) begin
            n_fail++; $display("FAIL wrap_top got tid=%0d pc=%h want tid=0 pc=fffffffc", fetch_tid, fetch_pc);
        end
        tick(); tick();
        n_checks++;
        if (fetch_tid !== 2'd0 || fetch_pc !== 32'h0) begin
            n_fail++; $display("FAIL wrap_zero got tid=%0d pc=%h want tid=0 pc=00000000", fetch_tid, fetch_pc);
        end
    endtask

    task automatic test_midstream_reset();
        tick();
        rst = 1'b1; start_mask = 3'b111;
        tick();
        n_checks++;
        if (fetch_valid !== 1'b0 || fetch_pc !== RPC || run_mask !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset got v=%b pc=%h mask=%b want v=0 pc=%h mask=000", fetch_valid, fetch_pc, run_mask, RPC);
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (fetch_valid !== 1'b1 || fetch_tid !== 2'(i) || fetch_pc !== RPC) begin
                n_fail++; $display("FAIL mid_reset_pc[%0d] got tid=%0d pc=%h want tid=%0d pc=%h", i, fetch_tid, fetch_pc, i, RPC);
            end
        end
    endtask

    task automatic test_random();
        do_reset(3'($urandom));
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            if (rst) start_mask = 3'($urandom);
            redirect_valid = ($urandom_range(0, 5) == 0);
            redirect_tid   = 2'($urandom_range(0, 3));
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom);
            stall_valid    = ($urandom_range(0, 3) == 0);
            stall_tid      = 2'($urandom_range(0, 3));
            wake_valid     = ($urandom_range(0, 2) == 0);
            wake_tid       = 2'($urandom_range(0, 3));
            halt_valid     = ($urandom_range(0, 7) == 0);
            halt_tid       = 2'($urandom_range(0, 3));
            tick();
            n_checks++;
            if (fetch_valid !== e_fv) begin
                n_fail++; $display("FAIL rand_valid[%0d] got=%b want=%b", cyc, fetch_valid, e_fv);
            end else if (e_fv) begin
                n_checks++;
                if (fetch_tid !== e_tid || fetch_pc !== e_pc) begin
                    n_fail++; $display("FAIL rand_fetch[%0d] got tid=%0d pc=%h want tid=%0d pc=%h", cyc, fetch_tid, fetch_pc, e_tid, e_pc);
                end
            end
            n_checks++;
            if (run_mask !== e_run) begin
                n_fail++; $display("FAIL rand_run_mask[%0d] got=%b want=%b", cyc, run_mask, e_run);
            end
        end
        rst = 1'b0;
        clear_events();
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_single_start();
        test_stall_wake();
        test_redirect_bypass();
        test_halt_wrap();
        test_midstream_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
